// File: rtl/trace_run_monitor_pkg.sv
// trace_run_monitor_pkg
// Shared definitions for the run monitor: the controller states, the
// halt-cause encodings reported on halt_cause, and the RV32 instruction
// words that end a run.
package trace_run_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_BREAK = 2'b01;  // EBREAK or ECALL
    localparam logic [1:0] CAUSE_LOOP  = 2'b10;  // jal x0, 0 (spin in place)
    localparam logic [1:0] CAUSE_LIMIT = 2'b11;  // run-cycle budget exhausted

    localparam logic [31:0] INSN_EBREAK   = 32'h0010_0073;
    localparam logic [31:0] INSN_ECALL    = 32'h0000_0073;
    localparam logic [31:0] INSN_JAL_SELF = 32'h0000_006F;

endpackage

// File: rtl/trace_run_monitor_if.sv
// trace_run_monitor_if
// Groups the processor debug inputs and the readout valid/ready port.
//   master : the monitor (consumes enable/dbg_*/rd_ready, drives rd_*)
//   slave  : the environment (drives enable/dbg_*/rd_ready, consumes rd_*)
interface trace_run_monitor_if #(
    parameter int XLEN = 32
) ();
    logic            enable;
    logic [XLEN-1:0] dbg_instruction;
    logic [XLEN-1:0] dbg_pc;
    logic [XLEN-1:0] dbg_result;
    logic            rd_valid;
    logic            rd_ready;
    logic [XLEN-1:0] rd_pc;
    logic [XLEN-1:0] rd_instruction;
    logic [XLEN-1:0] rd_result;

    modport master (
        input  enable, dbg_instruction, dbg_pc, dbg_result, rd_ready,
        output rd_valid, rd_pc, rd_instruction, rd_result
    );

    modport slave (
        output enable, dbg_instruction, dbg_pc, dbg_result, rd_ready,
        input  rd_valid, rd_pc, rd_instruction, rd_result
    );
endinterface

// File: rtl/trace_ring_mem.sv
// trace_ring_mem
// DEPTH x WIDTH storage for the trace ring: one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
//   clk              : write clock
//   wr_en/wr_addr/wr_data : write port
//   rd_addr/rd_data  : combinational read port
module trace_ring_mem #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/trace_run_monitor.sv
// trace_run_monitor
// Watches the processor debug outputs, records retired {pc, instruction,
// result} triples in a ring buffer and stops on EBREAK/ECALL, a self-loop
// or a cycle limit. After the halt the recorded entries are drained
// oldest-first over the rd_* valid/ready port.
//   clk, rst     : clock, asynchronous active-high reset
//   bus (master) : enable, dbg_* inputs; rd_valid/rd_ready/rd_* readout
//   halted       : high once a halt was detected (HALTED and DONE)
//   halt_cause   : 00 none, 01 break/ecall, 10 self-loop, 11 limit
//   cycle_count  : enabled RUN cycles
//   entry_count  : valid entries held
//   overflow     : sticky, an entry was overwritten or dropped
module trace_run_monitor
    import trace_run_monitor_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int DEPTH         = 16,
    parameter int MAX_CYCLES    = 100,
    parameter int WRAP_MODE     = 1,
    parameter int HALT_ON_ECALL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    trace_run_monitor_if.master      bus,
    output logic                     halted,
    output logic [1:0]               halt_cause,
    output logic [31:0]              cycle_count,
    output logic [$clog2(DEPTH):0]   entry_count,
    output logic                     overflow
);
    localparam int AW    = $clog2(DEPTH);
    localparam int ENT_W = AW + 1;
    localparam logic [ENT_W-1:0] FULL = ENT_W'(DEPTH);

    state_t            state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              wr_en;
    logic [1:0]        cause_nxt;
    logic [3*XLEN-1:0] rd_data;

    assign full  = (entry_count == FULL);
    // When full, only wrap mode keeps writing (over the oldest entry).
    assign wr_en = (state == ST_RUN) && bus.enable && (!full || WRAP_MODE != 0);

    assign bus.rd_valid = (state == ST_HALTED) && (entry_count != '0);
    assign {bus.rd_pc, bus.rd_instruction, bus.rd_result} = rd_data;

    // Halt decode, highest priority first.
    always_comb begin
        cause_nxt = CAUSE_NONE;
        if (bus.dbg_instruction == XLEN'(INSN_EBREAK) ||
            (HALT_ON_ECALL != 0 && bus.dbg_instruction == XLEN'(INSN_ECALL))) begin
            cause_nxt = CAUSE_BREAK;
        end else if (bus.dbg_instruction == XLEN'(INSN_JAL_SELF)) begin
            cause_nxt = CAUSE_LOOP;
        end else if (cycle_count == 32'(MAX_CYCLES - 1)) begin
            cause_nxt = CAUSE_LIMIT;
        end
    end

    trace_ring_mem #(
        .WIDTH (3 * XLEN),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data ({bus.dbg_pc, bus.dbg_instruction, bus.dbg_result}),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            halted      <= 1'b0;
            halt_cause  <= CAUSE_NONE;
            cycle_count <= '0;
            entry_count <= '0;
            overflow    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.enable) begin
                        cycle_count <= cycle_count + 32'd1;
                        if (!full) begin
                            wr_ptr      <= wr_ptr + 1'b1;
                            entry_count <= entry_count + 1'b1;
                        end else begin
                            overflow <= 1'b1;
                            // Wrap mode: the read pointer follows the write
                            // pointer so it always names the oldest entry.
                            if (WRAP_MODE != 0) begin
                                wr_ptr <= wr_ptr + 1'b1;
                                rd_ptr <= rd_ptr + 1'b1;
                            end
                        end
                        if (cause_nxt != CAUSE_NONE) begin
                            state      <= ST_HALTED;
                            halted     <= 1'b1;
                            halt_cause <= cause_nxt;
                        end
                    end
                end
                ST_HALTED: begin
                    if (entry_count == '0) begin
                        state <= ST_DONE;
                    end else if (bus.rd_ready) begin
                        rd_ptr      <= rd_ptr + 1'b1;
                        entry_count <= entry_count - 1'b1;
                        if (entry_count == ENT_W'(1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_trace_run_monitor.sv
// tb_trace_run_monitor
// Directed bench for trace_run_monitor. Four instances share one stimulus
// stream: A (DEPTH 16, limit 100), B (DEPTH 4, wrap), C (DEPTH 4, no wrap)
// and D (DEPTH 16, limit 5). Each phase checks the instance it targets.
module tb_trace_run_monitor;
    import trace_run_monitor_pkg::*;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RMSK = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] result;
    logic        rd_ready;

    int checks;
    int failures;

    trace_run_monitor_if #(.XLEN(32)) if_a ();
    trace_run_monitor_if #(.XLEN(32)) if_b ();
    trace_run_monitor_if #(.XLEN(32)) if_c ();
    trace_run_monitor_if #(.XLEN(32)) if_d ();

    assign if_a.enable = enable;  assign if_a.dbg_instruction = instr;
    assign if_a.dbg_pc = pc;      assign if_a.dbg_result = result;
    assign if_a.rd_ready = rd_ready;
    assign if_b.enable = enable;  assign if_b.dbg_instruction = instr;
    assign if_b.dbg_pc = pc;      assign if_b.dbg_result = result;
    assign if_b.rd_ready = rd_ready;
    assign if_c.enable = enable;  assign if_c.dbg_instruction = instr;
    assign if_c.dbg_pc = pc;      assign if_c.dbg_result = result;
    assign if_c.rd_ready = rd_ready;
    assign if_d.enable = enable;  assign if_d.dbg_instruction = instr;
    assign if_d.dbg_pc = pc;      assign if_d.dbg_result = result;
    assign if_d.rd_ready = rd_ready;

    logic        halted_a, halted_b, halted_c, halted_d;
    logic [1:0]  cause_a, cause_b, cause_c, cause_d;
    logic [31:0] cyc_a, cyc_b, cyc_c, cyc_d;
    logic [4:0]  ent_a, ent_d;
    logic [2:0]  ent_b, ent_c;
    logic        ovf_a, ovf_b, ovf_c, ovf_d;

    trace_run_monitor #(.XLEN(32), .DEPTH(16), .MAX_CYCLES(100), .WRAP_MODE(1), .HALT_ON_ECALL(1)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a), .halted(halted_a), .halt_cause(cause_a),
        .cycle_count(cyc_a), .entry_count(ent_a), .overflow(ovf_a));
    trace_run_monitor #(.XLEN(32), .DEPTH(4), .MAX_CYCLES(100), .WRAP_MODE(1), .HALT_ON_ECALL(1)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b), .halted(halted_b), .halt_cause(cause_b),
        .cycle_count(cyc_b), .entry_count(ent_b), .overflow(ovf_b));
    trace_run_monitor #(.XLEN(32), .DEPTH(4), .MAX_CYCLES(100), .WRAP_MODE(0), .HALT_ON_ECALL(1)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c), .halted(halted_c), .halt_cause(cause_c),
        .cycle_count(cyc_c), .entry_count(ent_c), .overflow(ovf_c));
    trace_run_monitor #(.XLEN(32), .DEPTH(16), .MAX_CYCLES(5), .WRAP_MODE(1), .HALT_ON_ECALL(1)) dut_d (
        .clk(clk), .rst(rst), .bus(if_d), .halted(halted_d), .halt_cause(cause_d),
        .cycle_count(cyc_d), .entry_count(ent_d), .overflow(ovf_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    // Present one enabled sample; it is captured on the following rising edge.
    task automatic feed(input logic [31:0] i, input logic [31:0] p);
        enable = 1'b1;
        instr  = i;
        pc     = p;
        result = p ^ RMSK;
        @(negedge clk);
    endtask

    task automatic idle();
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        enable   = 1'b0;
        rd_ready = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        enable   = 1'b0;
        rd_ready = 1'b0;
        instr    = NOP;
        pc       = '0;
        result   = '0;

        // Reset state
        @(negedge clk);
        check_eq("rst_halted", {31'd0, halted_a}, 32'd0);
        check_eq("rst_cause", {30'd0, cause_a}, 32'd0);
        check_eq("rst_cycles", cyc_a, 32'd0);
        check_eq("rst_entries", {27'd0, ent_a}, 32'd0);
        check_eq("rst_overflow", {31'd0, ovf_a}, 32'd0);
        check_eq("rst_rd_valid", {31'd0, if_a.rd_valid}, 32'd0);
        rst = 1'b0;

        // Five NOPs then EBREAK at 0x14, drain in order
        for (int k = 0; k < 5; k++) feed(NOP, 32'(4 * k));
        feed(INSN_EBREAK, 32'h14);
        enable = 1'b0;
        check_eq("p1_halted", {31'd0, halted_a}, 32'd1);
        check_eq("p1_cause", {30'd0, cause_a}, 32'd1);
        check_eq("p1_cycles", cyc_a, 32'd6);
        check_eq("p1_entries", {27'd0, ent_a}, 32'd6);
        for (int k = 0; k < 6; k++) begin
            check_eq("p1_rd_valid", {31'd0, if_a.rd_valid}, 32'd1);
            check_eq("p1_rd_pc", if_a.rd_pc, 32'(4 * k));
            check_eq("p1_rd_result", if_a.rd_result, 32'(4 * k) ^ RMSK);
            check_eq("p1_rd_instr", if_a.rd_instruction, (k == 5) ? INSN_EBREAK : NOP);
            rd_ready = 1'b1;
            @(negedge clk);
        end
        rd_ready = 1'b0;
        check_eq("p1_done_valid", {31'd0, if_a.rd_valid}, 32'd0);
        check_eq("p1_done_entries", {27'd0, ent_a}, 32'd0);
        check_eq("p1_done_halted", {31'd0, halted_a}, 32'd1);
        @(negedge clk);
        check_eq("p1_done_hold", {31'd0, if_a.rd_valid}, 32'd0);

        // Ten NOPs then EBREAK: wrap keeps the last 4, no-wrap the first 4
        do_reset();
        for (int k = 0; k < 10; k++) feed(NOP, 32'(4 * k));
        feed(INSN_EBREAK, 32'h28);
        enable = 1'b0;
        check_eq("p2_b_entries", {29'd0, ent_b}, 32'd4);
        check_eq("p2_b_overflow", {31'd0, ovf_b}, 32'd1);
        check_eq("p2_b_cause", {30'd0, cause_b}, 32'd1);
        check_eq("p2_c_entries", {29'd0, ent_c}, 32'd4);
        check_eq("p2_c_overflow", {31'd0, ovf_c}, 32'd1);
        check_eq("p2_c_cycles", cyc_c, 32'd11);
        check_eq("p2_a_overflow", {31'd0, ovf_a}, 32'd0);
        check_eq("p2_a_entries", {27'd0, ent_a}, 32'd11);
        for (int k = 0; k < 4; k++) begin
            check_eq("p2_b_rd_pc", if_b.rd_pc, 32'h1C + 32'(4 * k));
            check_eq("p2_c_rd_pc", if_c.rd_pc, 32'(4 * k));
            check_eq("p2_b_rd_valid", {31'd0, if_b.rd_valid}, 32'd1);
            if (k == 1) begin
                rd_ready = 1'b0;
                @(negedge clk);
                check_eq("p2_stall_b_pc", if_b.rd_pc, 32'h20);
                check_eq("p2_stall_c_pc", if_c.rd_pc, 32'h4);
                check_eq("p2_stall_b_entries", {29'd0, ent_b}, 32'd3);
            end
            rd_ready = 1'b1;
            @(negedge clk);
        end
        rd_ready = 1'b0;
        check_eq("p2_b_done_valid", {31'd0, if_b.rd_valid}, 32'd0);
        check_eq("p2_c_done_valid", {31'd0, if_c.rd_valid}, 32'd0);

        // Cycle limit 5 with a disabled cycle in the middle
        do_reset();
        feed(NOP, 32'h0);
        feed(NOP, 32'h4);
        idle();
        feed(NOP, 32'h8);
        feed(NOP, 32'hC);
        check_eq("p3_not_halted", {31'd0, halted_d}, 32'd0);
        check_eq("p3_cycles_pre", cyc_d, 32'd4);
        feed(NOP, 32'h10);
        enable = 1'b0;
        check_eq("p3_halted", {31'd0, halted_d}, 32'd1);
        check_eq("p3_cause", {30'd0, cause_d}, 32'd3);
        check_eq("p3_cycles", cyc_d, 32'd5);
        check_eq("p3_entries", {27'd0, ent_d}, 32'd5);
        @(negedge clk);
        check_eq("p3_cycles_frozen", cyc_d, 32'd5);

        // EBREAK on the limit cycle outranks the limit
        do_reset();
        for (int k = 0; k < 4; k++) feed(NOP, 32'(4 * k));
        feed(INSN_EBREAK, 32'h10);
        enable = 1'b0;
        check_eq("p4_limit_break_cause", {30'd0, cause_d}, 32'd1);
        check_eq("p4_limit_break_cycles", cyc_d, 32'd5);

        // Self-loop halts on the first sample
        do_reset();
        feed(INSN_JAL_SELF, 32'h0);
        enable = 1'b0;
        check_eq("p4_loop_cause_d", {30'd0, cause_d}, 32'd2);
        check_eq("p4_loop_cause_a", {30'd0, cause_a}, 32'd2);
        check_eq("p4_loop_cycles", cyc_a, 32'd1);
        check_eq("p4_loop_halted", {31'd0, halted_a}, 32'd1);

        // Asynchronous reset mid-drain, then a fresh run
        do_reset();
        feed(NOP, 32'h0);
        feed(NOP, 32'h4);
        feed(NOP, 32'h8);
        feed(INSN_EBREAK, 32'hC);
        enable   = 1'b0;
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        @(negedge clk);
        check_eq("p5_stall_pc", if_a.rd_pc, 32'h4);
        check_eq("p5_stall_entries", {27'd0, ent_a}, 32'd3);
        rd_ready = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("p5_arst_halted", {31'd0, halted_a}, 32'd0);
        check_eq("p5_arst_cause", {30'd0, cause_a}, 32'd0);
        check_eq("p5_arst_cycles", cyc_a, 32'd0);
        check_eq("p5_arst_entries", {27'd0, ent_a}, 32'd0);
        check_eq("p5_arst_rd_valid", {31'd0, if_a.rd_valid}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        rd_ready = 1'b0;
        feed(NOP, 32'h100);
        feed(NOP, 32'h104);
        feed(INSN_EBREAK, 32'h108);
        enable = 1'b0;
        check_eq("p5_new_entries", {27'd0, ent_a}, 32'd3);
        check_eq("p5_new_cycles", cyc_a, 32'd3);
        check_eq("p5_new_first_pc", if_a.rd_pc, 32'h100);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        check_eq("p5_new_second_pc", if_a.rd_pc, 32'h104);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
